// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, least-significant first,
// with the decimal carry rippled through a register between digits.

module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);
  logic [4:0] t;
  logic [4:0] t_adj;

  always_comb begin
    t     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    t_adj = t + 5'd6;
    d     = t[3:0];
    cout  = 1'b0;
    // Digits above 9 are not trapped; they fall through the same >9 correction.
    if (t > 5'd9) begin
      d    = t_adj[3:0];
      cout = 1'b1;
    end
  end
endmodule

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  invalid
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DIGITS-1:0][3:0] a_q, a_d, b_q, b_d;
  logic [DIGITS-1:0][3:0] work_q, work_d;
  logic [DIGITS-1:0][3:0] sum_q, sum_d;
  logic                   c_q, c_d;
  logic                   carry_out_q, carry_out_d;
  logic                   invalid_q, invalid_d;
  logic                   done_q, done_d;

  logic [3:0]             dig_sum;
  logic                   dig_cout;
  logic [DIGITS-1:0]      digit_bad;

  bcd_digit_add u_dig (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (c_q),
    .d    (dig_sum),
    .cout (dig_cout)
  );

  for (genvar i = 0; i < DIGITS; i++) begin : g_bad
    assign digit_bad[i] = (a_q[i] > 4'd9) | (b_q[i] > 4'd9);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    work_d      = work_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    invalid_d   = invalid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = carry_in;
          idx_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[idx_q] = dig_sum;
        c_d           = dig_cout;
        idx_d         = idx_q + IW'(1);
        if (idx_q == IW'(DIGITS - 1)) begin
          sum_d       = work_d;
          carry_out_d = dig_cout;
          invalid_d   = |digit_bad;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      work_q      <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      invalid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      work_q      <= work_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      invalid_q   <= invalid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign invalid   = invalid_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: expected results are queued at issue
// time and checked by an independent monitor whenever done pulses.

module tb_bcd_serial_adder;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         busy, done, carry_out, invalid;
  logic [W-1:0] sum;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         inv;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   busy_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: scores every done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) begin
      busy_len = 0;
    end else begin
      if (busy === 1'b1) busy_len++;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", W'(1), W'(0));
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.sum);
          check("carry_out", W'(carry_out), W'(e.cout));
          check("invalid", W'(invalid), W'(e.inv));
          check("latency", W'(cyc), W'(e.done_cyc));
          check("busy_cycles", W'(busy_len), W'(DIGITS));
        end
        busy_len = 0;
      end
    end
  end

  // Called at a negedge; start is sampled by the next posedge.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic cin,
                       input logic [W-1:0] es, input logic ec, input logic ei);
    exp_t e;
    a = va; b = vb; carry_in = cin; start = 1'b1;
    e.sum = es; e.cout = ec; e.inv = ei; e.done_cyc = cyc + DIGITS + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", W'(0), W'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_sum", sum, W'(0));
    check("rst_carry_out", W'(carry_out), W'(0));
    check("rst_invalid", W'(invalid), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h0037, 16'h0045, 1'b0, 16'h0082, 1'b0, 1'b0); wait_done(); idle(2);
    issue(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); wait_done(); idle(2);
    issue(16'h0777, 16'h0777, 1'b1, 16'h1555, 1'b0, 1'b0); wait_done(); idle(2);
    issue(16'h000E, 16'h0003, 1'b0, 16'h0017, 1'b0, 1'b1); wait_done(); idle(2);
    issue(16'h00FF, 16'h00FF, 1'b0, 16'h0154, 1'b0, 1'b1); wait_done(); idle(2);

    // Start while busy must be dropped, and inputs changing mid-op ignored.
    issue(16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0, 1'b0);
    a = 16'h9999; b = 16'h9999; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(); idle(8);

    // Back-to-back: start asserted in the done cycle.
    issue(16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0); wait_done();
    issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0); wait_done(); idle(2);

    // Abort after digit 2 has been processed.
    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    idle(2);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_sum", sum, W'(0));
    check("abort_carry_out", W'(carry_out), W'(0));
    check("abort_invalid", W'(invalid), W'(0));
    idle(8);
    issue(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0); wait_done(); idle(3);

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
